multi_timer: RTL and testbench

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 201 ++++++++++++++++++++
 tb/tb_multi_timer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Bank of NCH register-mapped down-counting timers with per-channel masked interrupts.
// Optional per-channel prescaler in CTRL[11:4] is enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             IRQ,
  output logic [NCH-1:0]   IRQ_vec
);

  localparam int unsigned PSC_W = 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  logic [1:0] sel_ch;
  logic [1:0] sel_reg;

  state_e             state_q  [NCH];
  state_e             state_d  [NCH];
  logic               en_q     [NCH];
  logic               en_d     [NCH];
  logic [1:0]         mode_q   [NCH];
  logic [1:0]         mode_d   [NCH];
  logic               im_q     [NCH];
  logic               im_d     [NCH];
  logic               pend_q   [NCH];
  logic               pend_d   [NCH];
  logic [CNT_W-1:0]   preset_q [NCH];
  logic [CNT_W-1:0]   preset_d [NCH];
  logic [CNT_W-1:0]   count_q  [NCH];
  logic [CNT_W-1:0]   count_d  [NCH];
  logic               tick     [NCH];
  logic               wr_ch    [NCH];

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PSC_W-1:0]   psc_q    [NCH];
  logic [PSC_W-1:0]   psc_d    [NCH];
  logic [PSC_W-1:0]   pcnt_q   [NCH];
  logic [PSC_W-1:0]   pcnt_d   [NCH];
`endif

  logic unused_bits;

  assign sel_ch  = Addr[5:4];
  assign sel_reg = Addr[3:2];

`ifdef MULTI_TIMER_PRESCALE_EN
  assign unused_bits = ^{Addr[31:6], Din[31:12]};
`else
  assign unused_bits = ^{Addr[31:6], Din[31:12], Din[11:4]};
`endif

  // State and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i]  <= ST_IDLE;
        en_q[i]     <= 1'b0;
        mode_q[i]   <= 2'b00;
        im_q[i]     <= 1'b0;
        pend_q[i]   <= 1'b0;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
`ifdef MULTI_TIMER_PRESCALE_EN
        psc_q[i]    <= '0;
        pcnt_q[i]   <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        en_q[i]     <= en_d[i];
        mode_q[i]   <= mode_d[i];
        im_q[i]     <= im_d[i];
        pend_q[i]   <= pend_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
`ifdef MULTI_TIMER_PRESCALE_EN
        psc_q[i]    <= psc_d[i];
        pcnt_q[i]   <= pcnt_d[i];
`endif
      end
    end
  end

  // Per-channel next state: a CPU write to a channel freezes its FSM and counter that cycle
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      en_d[i]     = en_q[i];
      mode_d[i]   = mode_q[i];
      im_d[i]     = im_q[i];
      pend_d[i]   = pend_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
`ifdef MULTI_TIMER_PRESCALE_EN
      psc_d[i]    = psc_q[i];
      pcnt_d[i]   = pcnt_q[i];
      tick[i]     = (pcnt_q[i] == psc_q[i]);
`else
      tick[i]     = 1'b1;
`endif
      wr_ch[i]    = WE && (sel_ch == 2'(i));

      if (wr_ch[i]) begin
        case (sel_reg)
          REG_CTRL: begin
            en_d[i]   = Din[0];
            mode_d[i] = Din[2:1];
            im_d[i]   = Din[3];
`ifdef MULTI_TIMER_PRESCALE_EN
            psc_d[i]  = Din[11:4];
`endif
          end
          REG_PRESET: preset_d[i] = Din[CNT_W-1:0];
          REG_COUNT:  ;
          REG_STATUS: if (Din[0]) pend_d[i] = 1'b0;
        endcase
      end else begin
        case (state_q[i])
          ST_IDLE: if (en_q[i]) state_d[i] = ST_LOAD;
          ST_LOAD: begin
            count_d[i] = preset_q[i];
`ifdef MULTI_TIMER_PRESCALE_EN
            pcnt_d[i]  = '0;
`endif
            state_d[i] = ST_CNT;
          end
          ST_CNT: begin
            if (!en_q[i]) begin
              state_d[i] = ST_IDLE;
            end else if (tick[i]) begin
              // PRESET of 0 or 1 both expire on the first tick
              if (count_q[i] > CNT_W'(1)) begin
                count_d[i] = count_q[i] - CNT_W'(1);
              end else begin
                count_d[i] = '0;
                pend_d[i]  = 1'b1;
                state_d[i] = ST_DONE;
              end
            end
`ifdef MULTI_TIMER_PRESCALE_EN
            pcnt_d[i] = tick[i] ? '0 : pcnt_q[i] + PSC_W'(1);
`endif
          end
          ST_DONE: begin
            if (mode_q[i] == 2'b01) begin
              state_d[i] = ST_LOAD;
            end else begin
              en_d[i]    = 1'b0;
              state_d[i] = ST_IDLE;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Combinational read mux; unimplemented channels read as zero
  always_comb begin
    Dout = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_ch == 2'(i)) begin
        case (sel_reg)
`ifdef MULTI_TIMER_PRESCALE_EN
          REG_CTRL:   Dout = {20'd0, psc_q[i], im_q[i], mode_q[i], en_q[i]};
`else
          REG_CTRL:   Dout = {28'd0, im_q[i], mode_q[i], en_q[i]};
`endif
          REG_PRESET: Dout = 32'(preset_q[i]);
          REG_COUNT:  Dout = 32'(count_q[i]);
          REG_STATUS: Dout = {29'd0, state_q[i], pend_q[i]};
        endcase
      end
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_irq
    assign IRQ_vec[g] = pend_q[g] & im_q[g];
  end

  assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized register traffic
// compared against a cycle-level behavioural model of the timer bank.
module tb_multi_timer;

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] CMASK = 32'h0000_FFFF;
`ifdef MULTI_TIMER_PRESCALE_EN
  localparam bit PSC_EN = 1'b1;
`else
  localparam bit PSC_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [31:2]    Addr;
  logic           WE;
  logic [31:0]    Din;
  logic [31:0]    Dout;
  logic           IRQ;
  logic [NCH-1:0] IRQ_vec;

  int checks   = 0;
  int failures = 0;

  multi_timer #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ),
    .IRQ_vec (IRQ_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: phase 0 idle, 1 load, 2 counting, 3 expired
  bit          m_en   [NCH];
  logic [1:0]  m_mode [NCH];
  bit          m_im   [NCH];
  bit          m_pend [NCH];
  int          m_psc  [NCH];
  int          m_el   [NCH];
  int          m_ph   [NCH];
  logic [31:0] m_pre  [NCH];
  logic [31:0] m_cnt  [NCH];

  function automatic logic [31:2] mk(input int ch, input int r);
    logic [31:2] v;
    v = '0;
    v[5:4] = 2'(ch);
    v[3:2] = 2'(r);
    return v;
  endfunction

  function automatic void model_step(input bit rst, input bit we, input logic [31:2] a,
                                     input logic [31:0] d);
    int wc;
    int wr;
    bit t;
    wc = int'(a[5:4]);
    wr = int'(a[3:2]);
    for (int c = 0; c < int'(NCH); c++) begin
      if (rst) begin
        m_en[c] = 0; m_mode[c] = 2'b00; m_im[c] = 0; m_pend[c] = 0;
        m_psc[c] = 0; m_el[c] = 0; m_ph[c] = 0; m_pre[c] = '0; m_cnt[c] = '0;
      end else if (we && wc == c) begin
        if (wr == 0) begin
          m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3];
          m_psc[c] = PSC_EN ? int'(d[11:4]) : 0;
        end else if (wr == 1) begin
          m_pre[c] = d & CMASK;
        end else if (wr == 3 && d[0]) begin
          m_pend[c] = 0;
        end
      end else begin
        case (m_ph[c])
          0: if (m_en[c]) m_ph[c] = 1;
          1: begin m_cnt[c] = m_pre[c]; m_el[c] = 0; m_ph[c] = 2; end
          2: begin
            if (!m_en[c]) begin
              m_ph[c] = 0;
            end else begin
              m_el[c] = m_el[c] + 1;
              t = (m_el[c] % (m_psc[c] + 1)) == 0;
              if (t) begin
                if (m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 32'd1;
                else begin m_cnt[c] = '0; m_pend[c] = 1; m_ph[c] = 3; end
              end
            end
          end
          default: begin
            if (m_mode[c] == 2'b01) m_ph[c] = 1;
            else begin m_en[c] = 0; m_ph[c] = 0; end
          end
        endcase
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int r);
    logic [31:0] v;
    v = '0;
    if (ch < int'(NCH)) begin
      case (r)
        0: begin v[0] = m_en[ch]; v[2:1] = m_mode[ch]; v[3] = m_im[ch]; v[11:4] = 8'(m_psc[ch]); end
        1: v = m_pre[ch];
        2: v = m_cnt[ch];
        default: begin v[0] = m_pend[ch]; v[2:1] = 2'(m_ph[ch]); end
      endcase
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0] model_vec();
    logic [NCH-1:0] v;
    for (int c = 0; c < int'(NCH); c++) v[c] = m_pend[c] & m_im[c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick_a(input bit rst, input bit we, input logic [31:2] a, input logic [31:0] d);
    reset = rst; WE = we; Addr = a; Din = d;
    @(posedge clk);
    model_step(rst, we, a, d);
    #1;
    WE = 1'b0; reset = 1'b0;
  endtask

  task automatic tick(input bit rst, input bit we, input int ch, input int r, input logic [31:0] d);
    tick_a(rst, we, mk(ch, r), d);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 32'd0);
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    Addr = mk(ch, r);
    #1;
    v = Dout;
  endtask

  task automatic chk_reg(input string tag, input int ch, input int r);
    logic [31:0] v;
    rd(ch, r, v);
    chk(tag, v, model_read(ch, r));
  endtask

  task automatic chk_irq(input string tag);
    chk({tag, "_irq"}, 32'(IRQ), 32'(|model_vec()));
    chk({tag, "_vec"}, 32'(IRQ_vec), 32'(model_vec()));
  endtask

  logic [31:0] v;
  int first, second, found, seen;
  int exp29 [4] = '{3, 2, 1, 0};
  int exp33 [7] = '{2, 2, 2, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    tick(1, 0, 0, 0, 32'd0);
    tick(1, 0, 0, 0, 32'd0);

    // Reset state
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_vec", 32'(IRQ_vec), 32'd0);
    for (int r = 0; r < 4; r++) begin rd(0, r, v); chk("rst_ch0", v, 32'd0); end
    idle(1);
    for (int r = 0; r < 4; r++) begin rd(1, r, v); chk("rst_ch1", v, 32'd0); end

    // One-shot on ch0, PRESET=3
    tick(0, 1, 0, 1, 32'd3);
    tick(0, 1, 0, 0, 32'h9);
    idle(1);
    rd(0, 3, v); chk("r029_load", 32'(v[2:1]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      rd(0, 2, v); chk("r029_cnt", v, 32'(exp29[k]));
    end
    rd(0, 3, v); chk("r029_pend", v & 32'd1, 32'd1);
    chk("r029_irq", 32'(IRQ), 32'd1);
    chk("r029_vec", 32'(IRQ_vec), 32'd1);
    idle(1);
    rd(0, 0, v); chk("r029_en_clr", v, 32'h8);
    chk_reg("r029_st", 0, 3);
    tick(0, 1, 0, 3, 32'd1);
    chk("r029_w1c", 32'(IRQ), 32'd0);

    // Auto-reload on ch1, PRESET=2
    tick(0, 1, 1, 1, 32'd2);
    tick(0, 1, 1, 0, 32'hB);
    first = -1; second = -1;
    for (int k = 0; k < 14; k++) begin
      idle(1);
      rd(1, 3, v);
      chk("r030_st", v, model_read(1, 3));
      if (v[2:1] == 2'b11) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("r030_period", 32'(second - first), 32'd4);
    chk("r030_irq_set", 32'(IRQ), 32'd1);
    tick(0, 1, 1, 3, 32'd1);
    chk("r030_irq_drop", 32'(IRQ), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk_reg("r030_cnt", 1, 2);
      if (IRQ) seen = 1;
    end
    chk("r030_resume", 32'(seen), 32'd1);
    tick(0, 1, 1, 0, 32'd0);
    idle(4);
    tick(0, 1, 1, 3, 32'd1);
    chk_reg("r030_stop", 1, 3);

    // Disable ch0 mid-count at COUNT=5
    tick(0, 1, 0, 1, 32'd10);
    tick(0, 1, 0, 0, 32'h1);
    found = 0;
    for (int k = 0; k < 30; k++) begin
      idle(1);
      rd(0, 2, v);
      if (v == 32'd5) begin found = 1; break; end
    end
    chk("r031_reach", 32'(found), 32'd1);
    tick(0, 1, 0, 0, 32'd0);
    idle(2);
    rd(0, 2, v); chk("r031_hold", v, 32'd5);
    rd(0, 3, v); chk("r031_idle", v, 32'd0);
    chk("r031_irq", 32'(IRQ), 32'd0);

    // Masked interrupts, PRESET=0 on ch0, unimplemented channels
    tick(0, 1, 0, 1, 32'd0);
    tick(0, 1, 0, 0, 32'h1);
    tick(0, 1, 1, 1, 32'd4);
    tick(0, 1, 1, 0, 32'h1);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("r032_irq", 32'(IRQ), 32'd0);
    end
    rd(0, 3, v); chk("r032_pend0", v & 32'd1, 32'd1);
    rd(1, 3, v); chk("r032_pend1", v & 32'd1, 32'd1);
    rd(3, 0, v); chk("r032_ch3_ctrl", v, 32'd0);
    rd(3, 1, v); chk("r032_ch3_pre", v, 32'd0);
    rd(2, 2, v); chk("r032_ch2_cnt", v, 32'd0);
    rd(3, 3, v); chk("r032_ch3_st", v, 32'd0);

`ifdef MULTI_TIMER_PRESCALE_EN
    // Prescaler PSC=2 slows counting to one step per three clocks
    tick(0, 1, 0, 1, 32'd2);
    tick(0, 1, 0, 0, 32'h21);
    idle(1);
    for (int k = 0; k < 7; k++) begin
      idle(1);
      rd(0, 2, v); chk("r033_psc", v, 32'(exp33[k]));
    end
`else
    // PSC bits absent: CTRL[11:4] reads zero
    tick(0, 1, 0, 0, 32'h29);
    rd(0, 0, v); chk("r033_ctrl", v, 32'h9);
    chk("r033_tbl", 32'(exp33[0]), 32'd2);
    tick(0, 1, 0, 0, 32'd0);
`endif

    // Reset mid-count at COUNT=7, with a colliding write
    tick(0, 1, 0, 0, 32'd0);
    idle(4);
    tick(0, 1, 0, 1, 32'd20);
    tick(0, 1, 0, 0, 32'h9);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      rd(0, 2, v);
      if (v == 32'd7) begin found = 1; break; end
    end
    chk("r034_reach", 32'(found), 32'd1);
    tick(1, 1, 1, 0, 32'hF);
    chk("r034_irq", 32'(IRQ), 32'd0);
    chk("r034_vec", 32'(IRQ_vec), 32'd0);
    for (int r = 0; r < 4; r++) begin rd(0, r, v); chk("r034_ch0", v, 32'd0); end
    idle(1);
    for (int r = 0; r < 4; r++) begin rd(1, r, v); chk("r034_ch1", v, 32'd0); end

    // Randomized register traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:2] a;
      logic [31:0] d;
      bit          we;
      bit          rst;
      int          ch;
      int          r;
      ch  = int'($urandom_range(0, 3));
      r   = int'($urandom_range(0, 3));
      we  = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 199) == 0);
      d   = $urandom;
      if (r == 1 && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 8));
      if (r == 0) begin
        d[11:4] = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end
      a = mk(ch, r);
      a[31:6] = 26'($urandom);
      tick_a(rst, we, a, d);
      chk_irq("rnd");
      chk_reg("rnd_cnt0", 0, 2);
      chk_reg("rnd_st0", 0, 3);
      chk_reg("rnd_cnt1", 1, 2);
      chk_reg("rnd_st1", 1, 3);
      chk_reg("rnd_any", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
